// File: rtl/neo_slot_ctrl_pkg.sv
// neo_slot_ctrl_pkg: shared FSM states, port wait-code values and counter sizing for the slot controller
package neo_slot_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_EXT, S_ACK, S_BERR} state_t;
    localparam logic [1:0] PW_0   = 2'b11;
    localparam logic [1:0] PW_1   = 2'b10;
    localparam logic [1:0] PW_2   = 2'b01;
    localparam logic [1:0] PW_EXT = 2'b00;
    function automatic int cnt_width(input int timeout, input int base_lat);
        return $clog2((timeout > base_lat + 3 ? timeout : base_lat + 3) + 1);
    endfunction
endpackage

// File: rtl/neo_slot_ctrl_wait_counter.sv
// neo_slot_ctrl_wait_counter: loadable up/down counter with zero and terminal-count flags
//   clk, rst_n     clock, async active-low reset
//   load/load_val  load a new count (wins over dec/inc)
//   dec, inc       count down / up by one
//   zero, term     count == 0 / count == TERM
module neo_slot_ctrl_wait_counter
    import neo_slot_ctrl_pkg::*;
#(
    parameter int CW   = 7,
    parameter int TERM = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    input  logic          inc,
    output logic          zero,
    output logic          term
);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= load ? load_val : dec ? cnt - CW'(1) : inc ? cnt + CW'(1) : cnt;
    assign zero = cnt == '0;
    assign term = cnt == CW'(TERM);
endmodule

// File: rtl/neo_slot_ctrl.sv
// neo_slot_ctrl: cartridge slot select, wait-state and DTACK/BERR generator for the 68K cart bus
//   CLK_68KCLK, nRESET             clock, async active-low reset
//   nAS, ROM_ZONE, PORT_ZONE       68K strobe and cart zone decode
//   SLOT_SEL                       slot number from the slot latch
//   nROMWAIT, nPWAIT0/1, PDTACK    per-slot wait configuration and external acknowledge
//   nSLOT                          registered one-hot active-low slot select
//   nDTACK, nBERR, BUSY            registered bus handshake outputs
module neo_slot_ctrl
    import neo_slot_ctrl_pkg::*;
#(
    parameter int NUM_SLOTS = 6,
    parameter int BASE_LAT  = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic                 CLK_68KCLK,
    input  logic                 nRESET,
    input  logic                 nAS,
    input  logic                 ROM_ZONE,
    input  logic                 PORT_ZONE,
    input  logic [2:0]           SLOT_SEL,
    input  logic [NUM_SLOTS-1:0] nROMWAIT,
    input  logic [NUM_SLOTS-1:0] nPWAIT0,
    input  logic [NUM_SLOTS-1:0] nPWAIT1,
    input  logic [NUM_SLOTS-1:0] PDTACK,
    output logic [NUM_SLOTS-1:0] nSLOT,
    output logic                 nDTACK,
    output logic                 nBERR,
    output logic                 BUSY
);
    localparam int CNT_W = cnt_width(TIMEOUT, BASE_LAT);
    state_t state, state_n;
    logic [2:0] slot_q, slot;
    logic [7:0] romw, pw0, pw1, pdt;
    logic [1:0] pcode;
    logic [CNT_W-1:0] ld_val;
    logic [NUM_SLOTS-1:0] nslot_n;
    logic nas_q, valid, start, ext, ld, cnt_dec, cnt_inc, zero, term, dtack_n, berr_n, busy_n;
    int w;
    // The slot tracks SLOT_SEL while idle and is frozen for the duration of a cycle.
    assign slot = state == S_IDLE ? SLOT_SEL : slot_q;
    assign valid = int'(slot) < NUM_SLOTS;
    // Widen per-slot vectors to the full 3-bit slot range so any SLOT_SEL indexes safely.
    assign romw = 8'(nROMWAIT);
    assign pw0 = 8'(nPWAIT0);
    assign pw1 = 8'(nPWAIT1);
    assign pdt = 8'(PDTACK);
    assign pcode = {pw1[slot], pw0[slot]};
    assign ext = !ROM_ZONE && pcode == PW_EXT;
    // A start needs a fresh falling strobe: the previous sample must have been high.
    assign start = !nAS && nas_q && (ROM_ZONE || PORT_ZONE);
    assign nslot_n = valid ? ~(NUM_SLOTS'(1) << slot) : '1;
    always_comb begin
        w = ROM_ZONE ? int'(!romw[slot]) : pcode == PW_0 ? 0 : pcode == PW_1 ? 1 : 2;
        ld_val = ext ? CNT_W'(1) : CNT_W'(BASE_LAT + w - 1);
    end
    neo_slot_ctrl_wait_counter #(.CW(CNT_W), .TERM(TIMEOUT)) u_cnt (
        .clk(CLK_68KCLK),
        .rst_n(nRESET),
        .load(ld),
        .load_val(ld_val),
        .dec(cnt_dec),
        .inc(cnt_inc),
        .zero(zero),
        .term(term)
    );
    always_ff @(posedge CLK_68KCLK or negedge nRESET)
        if (!nRESET) begin
            state  <= S_IDLE;
            slot_q <= '0;
            nas_q  <= 1'b0;
            nSLOT  <= ~(NUM_SLOTS'(1));
            nDTACK <= 1'b1;
            nBERR  <= 1'b1;
            BUSY   <= 1'b0;
        end else begin
            state  <= state_n;
            slot_q <= slot;
            nas_q  <= nAS;
            nSLOT  <= nslot_n;
            nDTACK <= dtack_n;
            nBERR  <= berr_n;
            BUSY   <= busy_n;
        end
    // In EXT the counter counts cycles since start; PDTACK is checked before the timeout so it wins a tie.
    always_comb begin
        state_n = state;
        ld = 1'b0;
        cnt_dec = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                state_n = !valid ? S_BERR : ext ? S_EXT : S_WAIT;
                ld = valid;
            end
            S_WAIT: if (nAS) state_n = S_IDLE;
                else if (zero) state_n = S_ACK;
                else cnt_dec = 1'b1;
            S_EXT: if (nAS) state_n = S_IDLE;
                else if (pdt[slot]) state_n = S_ACK;
                else if (term) state_n = S_BERR;
                else cnt_inc = 1'b1;
            S_ACK, S_BERR: if (nAS) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    // Outputs decode the next state so they are registered alongside it.
    always_comb begin
        dtack_n = state_n != S_ACK;
        berr_n = state_n != S_BERR;
        busy_n = state_n != S_IDLE;
    end
endmodule

// File: tb/tb_neo_slot_ctrl.sv
// tb_neo_slot_ctrl: directed self-checking bench for neo_slot_ctrl (6 slots, BASE_LAT 1, TIMEOUT 64)
module tb_neo_slot_ctrl;
    logic CLK_68KCLK = 1'b0;
    logic nRESET, nAS, ROM_ZONE, PORT_ZONE;
    logic [2:0] SLOT_SEL;
    logic [5:0] nROMWAIT, nPWAIT0, nPWAIT1, PDTACK, nSLOT;
    logic nDTACK, nBERR, BUSY;
    int vectors = 0;
    int miscompares = 0;

    neo_slot_ctrl #(.NUM_SLOTS(6), .BASE_LAT(1), .TIMEOUT(64)) dut (
        .CLK_68KCLK(CLK_68KCLK),
        .nRESET(nRESET),
        .nAS(nAS),
        .ROM_ZONE(ROM_ZONE),
        .PORT_ZONE(PORT_ZONE),
        .SLOT_SEL(SLOT_SEL),
        .nROMWAIT(nROMWAIT),
        .nPWAIT0(nPWAIT0),
        .nPWAIT1(nPWAIT1),
        .PDTACK(PDTACK),
        .nSLOT(nSLOT),
        .nDTACK(nDTACK),
        .nBERR(nBERR),
        .BUSY(BUSY)
    );

    always #5 CLK_68KCLK = ~CLK_68KCLK;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK_68KCLK);
        #1;
    endtask

    task automatic test_reset;
        logic [8:0] exp;
        nRESET = 1'b0; nAS = 1'b0; ROM_ZONE = 1'b0; PORT_ZONE = 1'b0; SLOT_SEL = 3'd3;
        nROMWAIT = '1; nPWAIT0 = '1; nPWAIT1 = '1; PDTACK = '0;
        #12;
        exp = 9'b111110_110;
        vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL reset_hold got=%b exp=%b", {nSLOT, nDTACK, nBERR, BUSY}, exp); end
        @(negedge CLK_68KCLK); nRESET = 1'b1;
        tick;
        exp = 9'b110111_110;
        vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL reset_release got=%b exp=%b", {nSLOT, nDTACK, nBERR, BUSY}, exp); end
        nAS = 1'b1;
        tick;
    endtask

    task automatic test_rom;
        logic [8:0] exp;
        SLOT_SEL = 3'd2; nROMWAIT = 6'b111011; ROM_ZONE = 1'b1; nAS = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            tick;
            exp = (k >= 2) ? 9'b111011_011 : 9'b111011_111;
            vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL rom_wait k=%0d got=%b exp=%b", k, {nSLOT, nDTACK, nBERR, BUSY}, exp); end
        end
        nAS = 1'b1; ROM_ZONE = 1'b0; nROMWAIT = '1;
        tick;
        exp = 9'b111011_110;
        vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL rom_release got=%b exp=%b", {nSLOT, nDTACK, nBERR, BUSY}, exp); end
    endtask

    task automatic test_port_wait;
        logic [8:0] exp;
        SLOT_SEL = 3'd1; nPWAIT1 = 6'b111101; nPWAIT0 = 6'b111111; PORT_ZONE = 1'b1; nAS = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            tick;
            if (k == 0) SLOT_SEL = 3'd4;
            exp = (k == 3) ? 9'b111101_011 : 9'b111101_111;
            vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL port_w2 k=%0d got=%b exp=%b", k, {nSLOT, nDTACK, nBERR, BUSY}, exp); end
        end
        nAS = 1'b1; PORT_ZONE = 1'b0;
        tick;
        exp = 9'b111101_110;
        vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL port_release got=%b exp=%b", {nSLOT, nDTACK, nBERR, BUSY}, exp); end
        tick;
        exp = 9'b101111_110;
        vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL port_slot_follow got=%b exp=%b", {nSLOT, nDTACK, nBERR, BUSY}, exp); end
    endtask

    task automatic test_port_codes;
        logic [2:0] slots [2] = '{3'd5, 3'd3};
        int lats [2] = '{1, 2};
        logic exp;
        nPWAIT1 = 6'b111111; nPWAIT0 = 6'b110111;
        for (int i = 0; i < 2; i++) begin
            SLOT_SEL = slots[i]; PORT_ZONE = 1'b1; nAS = 1'b0;
            for (int k = 0; k <= lats[i]; k++) begin
                tick;
                exp = (k == lats[i]) ? 1'b0 : 1'b1;
                vectors++; if (nDTACK !== exp) begin miscompares++; $display("FAIL port_code slot=%0d k=%0d got=%b exp=%b", slots[i], k, nDTACK, exp); end
            end
            nAS = 1'b1; PORT_ZONE = 1'b0;
            tick;
        end
        nPWAIT0 = '1;
    endtask

    task automatic test_ext;
        logic [2:0] exp;
        SLOT_SEL = 3'd0; nPWAIT1 = 6'b111110; nPWAIT0 = 6'b111110; PORT_ZONE = 1'b1;
        PDTACK = 6'b111110; nAS = 1'b0;
        tick;
        for (int k = 1; k <= 10; k++) begin
            tick;
            vectors++; if ({nDTACK, nBERR, BUSY} !== 3'b111) begin miscompares++; $display("FAIL ext_pend k=%0d got=%b exp=111", k, {nDTACK, nBERR, BUSY}); end
        end
        PDTACK = 6'b000001;
        tick;
        vectors++; if ({nDTACK, nBERR, BUSY} !== 3'b011) begin miscompares++; $display("FAIL ext_ack got=%b exp=011", {nDTACK, nBERR, BUSY}); end
        nAS = 1'b1; PDTACK = '0;
        tick;
        nAS = 1'b0;
        tick;
        for (int k = 1; k <= 63; k++) begin
            tick;
            vectors++; if ({nDTACK, nBERR, BUSY} !== 3'b111) begin miscompares++; $display("FAIL ext_to_pend k=%0d got=%b exp=111", k, {nDTACK, nBERR, BUSY}); end
        end
        for (int k = 64; k <= 65; k++) begin
            tick;
            vectors++; if ({nDTACK, nBERR, BUSY} !== 3'b101) begin miscompares++; $display("FAIL ext_timeout k=%0d got=%b exp=101", k, {nDTACK, nBERR, BUSY}); end
        end
        nAS = 1'b1;
        tick;
        vectors++; if ({nDTACK, nBERR, BUSY} !== 3'b110) begin miscompares++; $display("FAIL ext_berr_release got=%b exp=110", {nDTACK, nBERR, BUSY}); end
        nAS = 1'b0;
        tick;
        for (int k = 1; k <= 63; k++) tick;
        PDTACK = 6'b000001;
        tick;
        exp = {nDTACK, nBERR, BUSY};
        vectors++; if (exp !== 3'b011) begin miscompares++; $display("FAIL ext_tie got=%b exp=011", exp); end
        nAS = 1'b1; PDTACK = '0; PORT_ZONE = 1'b0;
        tick;
    endtask

    task automatic test_invalid;
        logic [8:0] exp;
        SLOT_SEL = 3'd6;
        tick;
        vectors++; if (nSLOT !== 6'b111111) begin miscompares++; $display("FAIL slot6_decode got=%b exp=111111", nSLOT); end
        SLOT_SEL = 3'd5;
        tick;
        vectors++; if (nSLOT !== 6'b011111) begin miscompares++; $display("FAIL slot5_decode got=%b exp=011111", nSLOT); end
        SLOT_SEL = 3'd7; ROM_ZONE = 1'b1; nAS = 1'b0;
        for (int k = 0; k <= 1; k++) begin
            tick;
            exp = 9'b111111_101;
            vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL invalid_berr k=%0d got=%b exp=%b", k, {nSLOT, nDTACK, nBERR, BUSY}, exp); end
        end
        nAS = 1'b1; ROM_ZONE = 1'b0;
        tick;
        exp = 9'b111111_110;
        vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL invalid_release got=%b exp=%b", {nSLOT, nDTACK, nBERR, BUSY}, exp); end
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp;
        SLOT_SEL = 3'd0; nPWAIT1 = 6'b111110; nPWAIT0 = 6'b111110; nROMWAIT = '1;
        ROM_ZONE = 1'b1; PORT_ZONE = 1'b1; nAS = 1'b0;
        tick;
        exp = 9'b111110_111;
        vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL rom_prec_e0 got=%b exp=%b", {nSLOT, nDTACK, nBERR, BUSY}, exp); end
        tick;
        exp = 9'b111110_011;
        vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL rom_prec_ack got=%b exp=%b", {nSLOT, nDTACK, nBERR, BUSY}, exp); end
        nAS = 1'b1; ROM_ZONE = 1'b0; PORT_ZONE = 1'b0;
        tick;
        nAS = 1'b0;
        tick;
        ROM_ZONE = 1'b1;
        for (int k = 0; k <= 1; k++) begin
            tick;
            vectors++; if ({nDTACK, BUSY} !== 2'b10) begin miscompares++; $display("FAIL no_restart k=%0d got=%b exp=10", k, {nDTACK, BUSY}); end
        end
        nAS = 1'b1;
        tick;
        nAS = 1'b0;
        tick;
        vectors++; if ({nDTACK, BUSY} !== 2'b11) begin miscompares++; $display("FAIL restart_busy got=%b exp=11", {nDTACK, BUSY}); end
        tick;
        vectors++; if ({nDTACK, BUSY} !== 2'b01) begin miscompares++; $display("FAIL restart_ack got=%b exp=01", {nDTACK, BUSY}); end
        nAS = 1'b1; ROM_ZONE = 1'b0; nPWAIT1 = '1; nPWAIT0 = '1;
        tick;
    endtask

    task automatic test_abort_reset;
        logic [8:0] exp;
        SLOT_SEL = 3'd1; nPWAIT1 = 6'b111101; nPWAIT0 = '1; PORT_ZONE = 1'b1; nAS = 1'b0;
        tick;
        tick;
        nAS = 1'b1;
        for (int k = 2; k <= 3; k++) begin
            tick;
            vectors++; if ({nDTACK, nBERR, BUSY} !== 3'b110) begin miscompares++; $display("FAIL abort k=%0d got=%b exp=110", k, {nDTACK, nBERR, BUSY}); end
        end
        nAS = 1'b0;
        for (int k = 0; k <= 3; k++) tick;
        vectors++; if ({nDTACK, nBERR, BUSY} !== 3'b011) begin miscompares++; $display("FAIL abort_retry_ack got=%b exp=011", {nDTACK, nBERR, BUSY}); end
        #3;
        nRESET = 1'b0;
        #1;
        exp = 9'b111110_110;
        vectors++; if ({nSLOT, nDTACK, nBERR, BUSY} !== exp) begin miscompares++; $display("FAIL async_reset got=%b exp=%b", {nSLOT, nDTACK, nBERR, BUSY}, exp); end
        nAS = 1'b1; PORT_ZONE = 1'b0;
        @(negedge CLK_68KCLK); nRESET = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_rom;
        test_port_wait;
        test_port_codes;
        test_ext;
        test_invalid;
        test_back_to_back;
        test_abort_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
